// File: rtl/in_unit_pkg.sv
// in_unit_pkg: shared ROB/CDB types and defaults for the IN-instruction input path.
package in_unit_pkg;
  localparam int ROB_WIDTH = 4;
  localparam int IN_FIFO_DEPTH = 16;
  typedef struct packed {
    logic valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0] data;
  } cdb_t;
  typedef struct packed {
    logic done;
    logic [ROB_WIDTH-1:0] tag;
  } in_entry_t;
endpackage

// File: rtl/in_fifo.sv
// in_fifo: receive byte FIFO with pop at head and peek at any offset from the head.
module in_fifo import in_unit_pkg::*; #(
  parameter int DEPTH = IN_FIFO_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  logic [7:0] din,
  input  logic [AW-1:0] offset,
  output logic [7:0] peek,
  output logic [AW:0] count,
  output logic full
);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  always_ff @(posedge clk) if (push) mem[tail] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign peek = mem[head + offset];
  // depth is a power of two, so the count MSB alone marks full
  assign full = count[AW];
endmodule

// File: rtl/in_unit.sv
// in_unit: buffers receiver bytes and feeds them in program order to pending IN instructions.
// Define IN_DROP_COUNT_EN to drop overflow bytes (counted in drop_count) instead of backpressuring.
module in_unit import in_unit_pkg::*; #(
  parameter int N_ENTRY = 4,
  parameter int FIFO_DEPTH = IN_FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  input  logic receiver_valid,
  input  logic [7:0] receiver_out,
  output logic receiver_ready,
  input  logic issue_valid,
  output logic issue_ready,
  input  logic [ROB_WIDTH-1:0] issue_tag,
  output logic cdb_valid,
  input  logic cdb_ready,
  output logic result_valid,
  output logic [ROB_WIDTH-1:0] result_tag,
  output logic [31:0] result_data,
  input  logic commit_valid,
  output logic commit_ready
`ifdef IN_DROP_COUNT_EN
  ,
  output logic [15:0] drop_count
`endif
);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(N_ENTRY + 1);
  localparam int SW = $clog2(N_ENTRY);
  in_entry_t pend [N_ENTRY];
  in_entry_t pend_nxt [N_ENTRY];
  logic [PW-1:0] pend_count, count_nxt;
  logic [FW:0] fifo_count;
  logic [7:0] peek;
  logic full, commit, push, issue, bcast, hit;
  logic [SW-1:0] sel, ins;
  cdb_t res;
  assign commit_ready = pend_count != '0 && pend[0].done;
  assign commit = commit_valid && commit_ready;
  assign push = receiver_valid && (!full || commit);
  assign issue_ready = commit || pend_count < PW'(N_ENTRY);
  assign issue = issue_valid && issue_ready && !flush;
  assign bcast = hit && cdb_ready && !flush;
  assign ins = SW'(commit ? pend_count - 1'b1 : pend_count);
  in_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .reset_n, .push, .pop(commit), .din(receiver_out),
    .offset(FW'(sel)), .peek, .count(fifo_count), .full
  );
  // entry j is bound to the byte j places behind the FIFO head
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int j = N_ENTRY - 1; j >= 0; j--)
      if (PW'(j) < pend_count && !pend[j].done && (FW+1)'(j) < fifo_count) begin
        hit = 1'b1;
        sel = SW'(j);
      end
  end
  assign res = {hit, pend[sel].tag, 24'b0, peek};
  assign cdb_valid = hit;
  assign result_valid = res.valid;
  assign result_tag = res.tag;
  assign result_data = res.data;
  always_comb begin
    pend_nxt = pend;
    if (bcast) pend_nxt[sel].done = 1'b1;
    if (commit) begin
      for (int k = 0; k < N_ENTRY - 1; k++) pend_nxt[k] = pend_nxt[k + 1];
      pend_nxt[N_ENTRY - 1] = '0;
    end
    if (issue) pend_nxt[ins] = '{done: 1'b0, tag: issue_tag};
    count_nxt = pend_count + PW'(issue) - PW'(commit);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pend_count <= '0;
      for (int k = 0; k < N_ENTRY; k++) pend[k] <= '0;
    end else if (flush) begin
      pend_count <= '0;
      for (int k = 0; k < N_ENTRY; k++) pend[k].done <= 1'b0;
    end else begin
      pend_count <= count_nxt;
      pend <= pend_nxt;
    end
`ifdef IN_DROP_COUNT_EN
  assign receiver_ready = 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) drop_count <= '0;
    else if (receiver_valid && !push && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
`else
  assign receiver_ready = !full || commit;
`endif
endmodule
